// File: rtl/ifetch_unit.sv
// ifetch_unit: miniRV fetch stage; owns the PC, issues credit-limited word requests and buffers responses.
// Optional IFU_PERF_CNT_EN adds perf_fetch_o / perf_stall_o counters.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEP = (CW+1)'(DEPTH);
    typedef enum logic {BOOT, RUN} state_t;
    state_t state, state_nxt;
    logic [31:0] fetch_pc;
    logic [CW-1:0] count, inflight, discard, wr_pos;
    logic [31:0] q_inst [DEPTH];
    logic [31:0] q_pc [DEPTH];
    logic [31:0] pq [DEPTH];
    logic [PW-1:0] pq_wr, pq_rd;
    logic [CW:0] credit;
    logic grant, rsp, push, pop, unused_bits;
    assign unused_bits  = ^redirect_pc_i[1:0];
    assign credit       = {1'b0, count} + {1'b0, inflight};
    assign imem_addr_o  = fetch_pc;
    assign inst_valid_o = count != '0;
    assign inst_o       = q_inst[0];
    assign inst_pc_o    = q_pc[0];
    assign grant        = imem_req_o & imem_gnt_i;
    assign rsp          = imem_rvalid_i & (inflight != '0);
    assign push         = rsp & (discard == '0) & ~redirect_i;
    assign pop          = inst_valid_o & inst_ready_i & ~redirect_i;
    assign wr_pos       = count - CW'(pop);
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= BOOT;
        else          state <= state_nxt;
    end
    always_comb begin
        state_nxt  = RUN;
        imem_req_o = (state == RUN) & ~redirect_i & (credit < DEP);
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            pq_wr    <= '0;
            pq_rd    <= '0;
        end else begin
            inflight <= inflight + CW'(grant) - CW'(rsp);
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
                pq_wr    <= pq_wr + 1'b1;
            end
            if (rsp) pq_rd <= pq_rd + 1'b1;
            if (redirect_i) begin
                // every request still outstanding after this cycle belongs to the old stream
                fetch_pc <= {redirect_pc_i[31:2], 2'b00};
                discard  <= inflight - CW'(rsp);
                count    <= '0;
            end else begin
                if (rsp && discard != '0) discard <= discard - 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (grant) pq[pq_wr] <= fetch_pc;
    end
    // entry 0 is the visible head; it is left untouched when the last word leaves so outputs hold
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_inst[i] <= 32'h0000_0013;
                q_pc[i]   <= '0;
            end
        end else begin
            if (pop && count > CW'(1)) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    q_inst[i] <= q_inst[i+1];
                    q_pc[i]   <= q_pc[i+1];
                end
            end
            if (push) begin
                q_inst[wr_pos[PW-1:0]] <= imem_rdata_i;
                q_pc[wr_pos[PW-1:0]]   <= pq[pq_rd];
            end
        end
    end
`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_fetch_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (pop) perf_fetch_o <= perf_fetch_o + 32'd1;
            if (state == RUN && !imem_req_o && !redirect_i) perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: randomized memory/decode environment checked every cycle against a queue-based fetch model.
module tb_ifetch_unit;
    localparam int DEPTH = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;
    logic        clk_i = 0, rst_n_i = 0;
    logic        imem_req_o, imem_gnt_i = 0, imem_rvalid_i = 0, redirect_i = 0;
    logic        inst_valid_o, inst_ready_i = 0;
    logic [31:0] imem_addr_o, imem_rdata_i = 0, redirect_pc_i = 0, inst_o, inst_pc_o;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_o, perf_stall_o;
`endif
    ifetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .inst_ready_i(inst_ready_i)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetch_o(perf_fetch_o), .perf_stall_o(perf_stall_o)
`endif
    );
    always #5 clk_i = ~clk_i;

    typedef struct {logic [31:0] pc; bit drop;} os_t;
    typedef struct {logic [31:0] inst; logic [31:0] pc;} fe_t;
    typedef struct {logic [31:0] a; int t;} mr_t;
    os_t oq[$];
    fe_t fq[$];
    mr_t mq[$];
    fe_t shown;
    bit m_run;
    logic [31:0] m_pc;
    int m_fetch, m_stall;
    int total = 0, bad = 0, cyc = 0;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_out();
        chk("valid", 32'(inst_valid_o), 32'(fq.size() > 0));
        chk("inst", inst_o, shown.inst);
        chk("inst_pc", inst_pc_o, shown.pc);
        if (inst_valid_o) chk("inst_vs_mem", inst_o, mw(inst_pc_o));
`ifdef IFU_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_o, 32'(m_fetch));
        chk("perf_stall", perf_stall_o, 32'(m_stall));
`endif
    endtask

    task automatic model_reset();
        oq.delete(); fq.delete(); mq.delete();
        shown = '{32'h0000_0013, 32'h0};
        m_run = 0; m_pc = RPC; m_fetch = 0; m_stall = 0;
    endtask

    // called at posedge+1: drive one cycle of inputs, check comb outputs, advance model and memory
    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit g, input bit rdy,
                         input bit ok_rsp, input bit spur);
        bit rsp, er;
        logic [31:0] rd;
        os_t e;
        rsp = ok_rsp && mq.size() > 0 && mq[0].t < cyc;
        rd = rsp ? mw(mq[0].a) : $urandom;
        redirect_i = redir; redirect_pc_i = rpc; imem_gnt_i = g; inst_ready_i = rdy;
        imem_rvalid_i = rsp || (spur && mq.size() == 0);
        imem_rdata_i = rd;
        #1;
        er = m_run && !redir && (fq.size() + oq.size() < DEPTH);
        chk("req", 32'(imem_req_o), 32'(er));
        chk("addr", imem_addr_o, m_pc);
        if (m_run && !er && !redir) m_stall++;
        if (fq.size() > 0 && rdy && !redir) begin
            void'(fq.pop_front());
            m_fetch++;
        end
        if (imem_rvalid_i && oq.size() > 0) begin
            e = oq.pop_front();
            if (!e.drop && !redir) fq.push_back('{rd, e.pc});
        end
        if (redir) begin
            fq.delete();
            foreach (oq[i]) oq[i].drop = 1;
            m_pc = {rpc[31:2], 2'b00};
        end else if (er && g) begin
            oq.push_back('{m_pc, 1'b0});
            m_pc += 32'd4;
        end
        if (fq.size() > 0) shown = fq[0];
        m_run = 1;
        if (rsp) void'(mq.pop_front());
        if (imem_req_o && g) mq.push_back('{imem_addr_o, cyc});
        @(posedge clk_i); #1; cyc++;
        check_out();
    endtask

    // called at posedge+1: asynchronous assert mid-cycle, release mid-cycle, ends at posedge+1 in RUN
    task automatic do_reset();
        #2 rst_n_i = 0;
        redirect_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; inst_ready_i = 0;
        #1;
        model_reset();
        chk("rst_valid", 32'(inst_valid_o), 32'h0);
        chk("rst_req", 32'(imem_req_o), 32'h0);
        chk("rst_inst", inst_o, 32'h0000_0013);
        chk("rst_pc", inst_pc_o, 32'h0);
        chk("rst_addr", imem_addr_o, RPC);
        repeat (2) @(posedge clk_i);
        #3 rst_n_i = 1;
        #1 chk("boot_req", 32'(imem_req_o), 32'h0);
        @(posedge clk_i); #1; cyc++;
        m_run = 1;
        check_out();
    endtask

    initial begin
        int gp, rp, yp, dp;
        model_reset();
        @(posedge clk_i); #1;
        do_reset();
        chk("first_req", 32'(imem_req_o), 32'h1);
        chk("first_addr", imem_addr_o, RPC);
        repeat (2) cycle(0, 0, 1, 1, 1, 0);
        chk("lat_valid", 32'(inst_valid_o), 32'h1);
        chk("lat_pc0", inst_pc_o, 32'h0);
        cycle(0, 0, 1, 1, 1, 0);
        chk("lat_pc4", inst_pc_o, 32'h4);
        repeat (10) cycle(0, 0, 1, 1, 1, 0);
        repeat (10) cycle(0, 0, 1, 0, 1, 0);
        chk("stall_req", 32'(imem_req_o), 32'h0);
        chk("stall_valid", 32'(inst_valid_o), 32'h1);
        repeat (10) cycle(0, 0, 1, 1, 1, 0);
        repeat (3) cycle(0, 0, 1, 1, 0, 0);
        cycle(1, 32'h100, 1, 1, 0, 0);
        chk("redir_addr", imem_addr_o, 32'h100);
        chk("redir_valid", 32'(inst_valid_o), 32'h0);
        repeat (10) cycle(0, 0, 1, 1, 1, 0);
        repeat (3) cycle(0, 0, 1, 1, 0, 0);
        cycle(1, 32'h300, 1, 1, 1, 0);
        repeat (10) cycle(0, 0, 1, 1, 1, 0);
        cycle(1, 32'h203, 0, 1, 1, 0);
        chk("align_addr", imem_addr_o, 32'h200);
        cycle(1, 32'h104, 0, 1, 1, 0);
        cycle(1, 32'hFFFF_FFFC, 0, 1, 1, 0);
        repeat (4) cycle(0, 0, 0, 1, 1, 0);
        chk("wrap_pre", imem_addr_o, 32'hFFFF_FFFC);
        cycle(0, 0, 1, 1, 1, 0);
        chk("wrap_addr", imem_addr_o, 32'h0);
        repeat (8) cycle(0, 0, 1, 0, 1, 0);
        chk("full_valid", 32'(inst_valid_o), 32'h1);
        do_reset();
        chk("restart_addr", imem_addr_o, RPC);
        for (int ep = 0; ep < 8; ep++) begin
            gp = $urandom_range(20, 100); rp = $urandom_range(20, 100);
            yp = $urandom_range(10, 100); dp = $urandom_range(0, 12);
            for (int k = 0; k < 500; k++)
                cycle($urandom_range(0, 99) < dp,
                      ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom,
                      $urandom_range(0, 99) < gp, $urandom_range(0, 99) < yp,
                      $urandom_range(0, 99) < rp, $urandom_range(0, 19) == 0);
            if (ep == 4) do_reset();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
